// File: rtl/l2_fifo_reader_pkg.sv
// Shared types and defaults for the L2 FIFO read-side endpoint.
package l2_config_and_types;

   localparam int DATA_WIDTH_DEF  = 32;
   localparam int COUNT_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } reader_state_t;

   function automatic logic holds_word(input reader_state_t s);
      return s != EMPTY;
   endfunction

endpackage

// File: rtl/l2_fifo_reader.sv
// Pops a fall-through FIFO into a registered main+skid output stage so that
// fifo_pop never depends combinationally on out_ready; counts delivered words.
module l2_fifo_reader
   import l2_config_and_types::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   fifo_valid,
   input  logic [DATA_WIDTH-1:0]  fifo_data,
   output logic                   fifo_pop,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_data,
   input  logic                   flush,
   output logic [COUNT_WIDTH-1:0] delivered_cnt
);

   reader_state_t          state_q, state_d;
   logic [DATA_WIDTH-1:0]  main_q, main_d;
   logic [DATA_WIDTH-1:0]  skid_q, skid_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   accept;

   assign out_valid     = holds_word(state_q);
   assign out_data      = main_q;
   assign delivered_cnt = cnt_q;
   assign accept        = out_valid & out_ready;

   // Pop looks only at registered state, fifo_valid and flush; gated low while in reset.
   assign fifo_pop = rst_n & fifo_valid & (flush | (state_q != TWO));

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      cnt_d   = cnt_q + {{(COUNT_WIDTH-1){1'b0}}, accept};

      if (flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (fifo_pop) begin
                  state_d = ONE;
                  main_d  = fifo_data;
               end
            end
            ONE: begin
               if (fifo_pop && accept) begin
                  main_d = fifo_data;
               end else if (fifo_pop) begin
                  state_d = TWO;
                  skid_d  = fifo_data;
               end else if (accept) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (accept) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // NOTE: data registers are reset too, so out_data is never X after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         cnt_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         cnt_q   <= cnt_d;
      end
   end

   a_pop_needs_valid : assert property (@(posedge clk) disable iff (!rst_n)
      fifo_pop |-> fifo_valid);

   a_no_pop_in_two : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == TWO && !flush) |-> !fifo_pop);

   a_stable_backpressure : assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_l2_fifo_reader.sv
// Randomized bench for l2_fifo_reader against a queue-based model of the FIFO and output stage.
module tb_l2_fifo_reader;

   localparam int DW = 32;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fifo_valid = 1'b0;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_pop;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          flush = 1'b0;
   logic [CW-1:0] delivered_cnt;

   logic          fifo_pop4;
   logic          out_valid4;
   logic [DW-1:0] out_data4;
   logic [3:0]    cnt4;

   always #5 clk = ~clk;

   l2_fifo_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) u_dut (
      .clk(clk), .rst_n(rst_n), .fifo_valid(fifo_valid), .fifo_data(fifo_data),
      .fifo_pop(fifo_pop), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .flush(flush), .delivered_cnt(delivered_cnt)
   );

   // Narrow-counter twin fed the same stimulus; only its counter is observed.
   l2_fifo_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .fifo_valid(fifo_valid), .fifo_data(fifo_data),
      .fifo_pop(fifo_pop4), .out_valid(out_valid4), .out_ready(out_ready),
      .out_data(out_data4), .flush(flush), .delivered_cnt(cnt4)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] fq[$];     // upstream FIFO contents
   logic [DW-1:0] outq[$];   // words held in the output stage, head first
   int unsigned   dcnt = 0;  // words accepted downstream
   bit            obs_v;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_fifo();
      fifo_valid = (fq.size() > 0);
      fifo_data  = (fq.size() > 0) ? fq[0] : '0;
   endtask

   // One clock: drive at negedge, check, let the edge happen, update the model.
   task automatic cycle(input bit rdy, input bit fl, input bit push_en, input logic [DW-1:0] w);
      bit            exp_v, pop_exp, acc, got_pop;
      logic [DW-1:0] head;
      if (push_en) fq.push_back(w);
      out_ready = rdy;
      flush     = fl;
      drive_fifo();
      #1;
      exp_v   = (outq.size() > 0);
      pop_exp = fifo_valid & (fl | (outq.size() < 2));
      obs_v   = out_valid;
      check("out_valid", 64'(out_valid), 64'(exp_v));
      if (exp_v) check("out_data", 64'(out_data), 64'(outq[0]));
      check("fifo_pop", 64'(fifo_pop), 64'(pop_exp));
      check("delivered_cnt", 64'(delivered_cnt), 64'(dcnt % 65536));
      check("cnt4", 64'(cnt4), 64'(dcnt % 16));
      acc     = exp_v & rdy;
      head    = fifo_data;
      got_pop = fifo_pop;
      @(posedge clk);
      if (acc) begin
         void'(outq.pop_front());
         dcnt++;
      end
      if (fl) outq.delete();
      else if (pop_exp) outq.push_back(head);
      if (got_pop && fq.size() > 0) void'(fq.pop_front());
      @(negedge clk);
   endtask

   // Asynchronous reset asserted between edges, with a word waiting in the FIFO.
   task automatic apply_reset();
      #2;
      rst_n = 1'b0;
      if (fq.size() == 0) fq.push_back(32'hDEAD_0000);
      drive_fifo();
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_cnt", 64'(delivered_cnt), 64'd0);
      check("rst_cnt4", 64'(cnt4), 64'd0);
      check("rst_fifo_pop", 64'(fifo_pop), 64'd0);
      fq.delete();
      outq.delete();
      dcnt = 0;
      drive_fifo();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int unsigned base;
      int          streak, best;

      @(negedge clk);
      apply_reset();

      // Single word: pop now, visible next cycle, counted the cycle after.
      cycle(1, 0, 1, 32'hA5A5_0001);
      cycle(1, 0, 0, '0);
      cycle(1, 0, 0, '0);
      check("single_cnt", 64'(delivered_cnt), 64'd1);

      // Backpressure: two words absorbed, third stays upstream.
      fq.push_back(32'h1);
      fq.push_back(32'h2);
      fq.push_back(32'h3);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0);
      check("bp_fifo_left", 64'(fq.size()), 64'd1);
      check("bp_head_held", 64'(out_data), 64'h1);
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, '0);
      check("bp_drained", 64'(fq.size() + outq.size()), 64'd0);

      // Streaming: 64 words back-to-back.
      base = dcnt;
      for (int i = 0; i < 64; i++) fq.push_back(DW'(i));
      streak = 0;
      best   = 0;
      for (int i = 0; i < 70; i++) begin
         cycle(1, 0, 0, '0);
         streak = obs_v ? streak + 1 : 0;
         if (streak > best) best = streak;
      end
      check("stream_run", 64'(best), 64'd64);
      check("stream_cnt", 64'(delivered_cnt), 64'((base + 64) % 65536));

      // Flush from TWO with two words still upstream.
      for (int i = 0; i < 4; i++) fq.push_back(32'hF000_0000 + DW'(i));
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0);
      check("fl_fifo_before", 64'(fq.size()), 64'd2);
      base = dcnt;
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, '0);
      cycle(0, 0, 0, '0);
      check("fl_out_valid", 64'(out_valid), 64'd0);
      check("fl_fifo_empty", 64'(fq.size()), 64'd0);
      check("fl_cnt_same", 64'(delivered_cnt), 64'(base % 65536));

      // Narrow counter wraps after 17 deliveries.
      apply_reset();
      for (int i = 0; i < 17; i++) fq.push_back(32'hC000_0000 + DW'(i));
      for (int i = 0; i < 20; i++) cycle(1, 0, 0, '0);
      check("wrap_cnt4", 64'(cnt4), 64'd1);
      check("wrap_cnt16", 64'(delivered_cnt), 64'd17);

      // Random traffic, backpressure, occasional flush and one mid-stream reset.
      for (int i = 0; i < 1000; i++) begin
         bit push;
         push = ($urandom_range(0, 1) == 1) && (fq.size() < 8);
         if (i == 500) apply_reset();
         cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0), push, $urandom);
      end
      for (int i = 0; i < 12; i++) cycle(1, 0, 0, '0);
      check("rand_drained", 64'(fq.size() + outq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
